multicycle_fsm: RTL and testbench

MULTICYCLE_FSM -- requirements
Module: multicycle_fsm

---
 rtl/multicycle_fsm_if.sv | 37 +++
 rtl/multicycle_fsm.sv | 131 +++++++++++++
 tb/tb_multicycle_fsm.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_fsm_if.sv
`default_nettype none
// ============================================================================
//  multicycle_fsm_if
//  Control bundle between the multicycle datapath and its main controller.
//  Rev 1.0 - initial release
// ============================================================================
interface multicycle_fsm_if;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       MemReady;
  logic       IRWrite;
  logic       AdrSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       Branch;
  logic       ALUOp;
  logic       Undef;
  logic       InstrDone;
  logic [3:0] State;

  modport master (
    output Op, Funct, MemReady,
    input  IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC,
           RegW, MemW, Branch, ALUOp, Undef, InstrDone, State
  );

  modport slave (
    input  Op, Funct, MemReady,
    output IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC,
           RegW, MemW, Branch, ALUOp, Undef, InstrDone, State
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_fsm.sv
`default_nettype none
// ============================================================================
//  multicycle_fsm
//  Main controller for a multicycle processor with memory wait-state support.
//  Rev 1.0 - initial release
// ============================================================================
module multicycle_fsm (
  input  wire logic         clk,
  input  wire logic         reset,
  multicycle_fsm_if.slave   bus
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXECR  = 4'd6;
  localparam logic [3:0] S_EXECI  = 4'd7;
  localparam logic [3:0] S_ALUWB  = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
  localparam logic [3:0] S_UNDEF  = 4'd10;

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic       w_ready;
  logic       unused_funct;

  // Handshake-driven pulses must stay low for the whole time reset is held.
  assign w_ready      = bus.MemReady & ~reset;
  assign unused_funct = ^bus.Funct[4:1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = bus.MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.Op)
          2'b00:   state_d = bus.Funct[5] ? S_EXECI : S_EXECR;
          2'b01:   state_d = S_MEMADR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_UNDEF;
        endcase
      end
      S_MEMADR: state_d = bus.Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = bus.MemReady ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = bus.MemReady ? S_FETCH : S_MEMWR;
      S_EXECR:  state_d = S_ALUWB;
      S_EXECI:  state_d = S_ALUWB;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    bus.IRWrite   = 1'b0;
    bus.AdrSrc    = 1'b0;
    bus.ALUSrcA   = 2'b00;
    bus.ALUSrcB   = 2'b00;
    bus.ResultSrc = 2'b00;
    bus.NextPC    = 1'b0;
    bus.RegW      = 1'b0;
    bus.MemW      = 1'b0;
    bus.Branch    = 1'b0;
    bus.ALUOp     = 1'b0;
    bus.Undef     = 1'b0;
    bus.InstrDone = 1'b0;
    bus.State     = state_q;
    case (state_q)
      S_FETCH: begin
        bus.ALUSrcA   = 2'b01;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
        bus.IRWrite   = w_ready;
        bus.NextPC    = w_ready;
      end
      S_DECODE: begin
        bus.ALUSrcA   = 2'b01;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
      end
      S_MEMADR: begin
        bus.ALUSrcB = 2'b01;
      end
      S_MEMRD: begin
        bus.AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        bus.ResultSrc = 2'b01;
        bus.RegW      = 1'b1;
        bus.InstrDone = 1'b1;
      end
      S_MEMWR: begin
        bus.AdrSrc    = 1'b1;
        bus.MemW      = 1'b1;
        bus.InstrDone = w_ready;
      end
      S_EXECR: begin
        bus.ALUOp = 1'b1;
      end
      S_EXECI: begin
        bus.ALUSrcB = 2'b01;
        bus.ALUOp   = 1'b1;
      end
      S_ALUWB: begin
        bus.RegW      = 1'b1;
        bus.InstrDone = 1'b1;
      end
      S_BRANCH: begin
        bus.ALUSrcB   = 2'b01;
        bus.ResultSrc = 2'b10;
        bus.Branch    = 1'b1;
        bus.InstrDone = 1'b1;
      end
      S_UNDEF: begin
        bus.Undef     = 1'b1;
        bus.InstrDone = 1'b1;
      end
      default: begin
        bus.State = state_q;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_fsm.sv
`default_nettype none
// ============================================================================
//  tb_multicycle_fsm
//  Randomized instruction streams checked against a per-instruction cycle model.
//  Rev 1.0 - initial release
// ============================================================================
module tb_multicycle_fsm;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  multicycle_fsm_if bus ();

  multicycle_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       mr;
    logic       drv;
  } cyc_t;

  cyc_t q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // {State,IRWrite,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,NextPC,RegW,MemW,Branch,ALUOp,Undef,InstrDone}
  function automatic logic [18:0] obs_vec();
    return {bus.State, bus.IRWrite, bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc,
            bus.NextPC, bus.RegW, bus.MemW, bus.Branch, bus.ALUOp, bus.Undef, bus.InstrDone};
  endfunction

  function automatic logic [18:0] exp_vec(input logic [3:0] st, input logic mr);
    case (st)
      4'd0:    return {4'd0, mr, 1'b0, 2'b01, 2'b10, 2'b10, mr, 6'b000000};
      4'd1:    return {4'd1, 1'b0, 1'b0, 2'b01, 2'b10, 2'b10, 1'b0, 6'b000000};
      4'd2:    return {4'd2, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 6'b000000};
      4'd3:    return {4'd3, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 6'b000000};
      4'd4:    return {4'd4, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 1'b0, 6'b100001};
      4'd5:    return {4'd5, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 5'b01000, mr};
      4'd6:    return {4'd6, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 6'b000100};
      4'd7:    return {4'd7, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 6'b000100};
      4'd8:    return {4'd8, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 6'b100001};
      4'd9:    return {4'd9, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 1'b0, 6'b001001};
      4'd10:   return {4'd10, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 6'b000011};
      default: return '0;
    endcase
  endfunction

  function automatic void push(input int st, input logic mr, input logic drv);
    cyc_t c;
    c.st  = 4'(st);
    c.mr  = mr;
    c.drv = drv;
    q.push_back(c);
  endfunction

  function automatic logic rbit();
    return logic'($urandom_range(0, 1));
  endfunction

  // Expected cycle trace of one instruction, built from its class and wait counts.
  function automatic int build(input logic [1:0] op, input logic [5:0] fn, input int nf, input int nm);
    int lat;
    q.delete();
    for (int i = 0; i < nf; i++) push(0, 1'b0, 1'b0);
    push(0, 1'b1, 1'b0);
    push(1, rbit(), 1'b1);
    case (op)
      2'b00: begin
        push(fn[5] ? 7 : 6, rbit(), 1'b0);
        push(8, rbit(), 1'b0);
        lat = 4;
      end
      2'b01: begin
        push(2, rbit(), 1'b1);
        if (fn[0]) begin
          for (int i = 0; i < nm; i++) push(3, 1'b0, 1'b0);
          push(3, 1'b1, 1'b0);
          push(4, rbit(), 1'b0);
          lat = 5 + nm;
        end else begin
          for (int i = 0; i < nm; i++) push(5, 1'b0, 1'b0);
          push(5, 1'b1, 1'b0);
          lat = 4 + nm;
        end
      end
      2'b10: begin
        push(9, rbit(), 1'b0);
        lat = 3;
      end
      default: begin
        push(10, rbit(), 1'b0);
        lat = 3;
      end
    endcase
    return lat + nf;
  endfunction

  task automatic run_instr(input logic [1:0] op, input logic [5:0] fn, input int nf, input int nm);
    int lat;
    int done_cnt;
    int done_at;
    int cyc;
    lat      = build(op, fn, nf, nm);
    done_cnt = 0;
    done_at  = -1;
    cyc      = 0;
    foreach (q[i]) begin
      @(negedge clk);
      bus.MemReady = q[i].mr;
      if (q[i].drv) begin
        bus.Op    = op;
        bus.Funct = fn;
      end else begin
        bus.Op    = 2'($urandom_range(0, 3));
        bus.Funct = 6'($urandom_range(0, 63));
      end
      #1;
      cyc++;
      check_eq($sformatf("cycle op=%0d st=%0d", op, q[i].st), 32'(obs_vec()), 32'(exp_vec(q[i].st, q[i].mr)));
      if (bus.InstrDone) begin
        done_cnt++;
        done_at = cyc;
      end
    end
    check_eq("instr_done_count", 32'(done_cnt), 32'd1);
    check_eq("instr_latency", 32'(done_at), 32'(lat));
  endtask

  initial begin
    n_checks     = 0;
    n_pass       = 0;
    reset        = 1'b1;
    bus.Op       = 2'b00;
    bus.Funct    = 6'd0;
    bus.MemReady = 1'b1;

    repeat (2) @(negedge clk);
    #1;
    check_eq("reset_state", 32'(obs_vec()), 32'(exp_vec(4'd0, 1'b0)));
    bus.MemReady = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    run_instr(2'b00, 6'b101000, 0, 0);
    run_instr(2'b00, 6'b000100, 0, 0);
    run_instr(2'b01, 6'b000001, 0, 2);
    run_instr(2'b01, 6'b000000, 0, 3);
    run_instr(2'b10, 6'b010101, 5, 0);
    run_instr(2'b11, 6'b111111, 0, 0);
    run_instr(2'b01, 6'b100001, 0, 0);
    run_instr(2'b01, 6'b100000, 0, 0);

    // Reset dropped into a stalled store: everything must collapse before the next edge.
    void'(build(2'b01, 6'b000000, 0, 3));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.MemReady = q[i].mr;
      bus.Op       = 2'b01;
      bus.Funct    = 6'b000000;
      #1;
      check_eq("pre_reset_store", 32'(obs_vec()), 32'(exp_vec(q[i].st, q[i].mr)));
    end
    #1 reset = 1'b1;
    #1;
    check_eq("async_reset_state", 32'(bus.State), 32'd0);
    check_eq("async_reset_memw", 32'(bus.MemW), 32'd0);
    bus.MemReady = 1'b1;
    #1;
    check_eq("reset_gates_pulses", 32'({bus.IRWrite, bus.NextPC, bus.InstrDone}), 32'd0);
    @(negedge clk);
    #1;
    check_eq("reset_held", 32'(obs_vec()), 32'(exp_vec(4'd0, 1'b0)));
    bus.MemReady = 1'b0;
    reset        = 1'b0;

    for (int k = 0; k < 60; k++) begin
      run_instr(2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
